// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the fetch / IF-ID stage and the control unit.
//   - RV32 opcodes that select an immediate format
//   - ImmSel encodings (I/S/B/J) consumed by the immediate extender
//   - default NOP word (addi x0,x0,0)
//   - fetch FSM state encodings
package fetch_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DROP  = 2'b11
    } state_e;

endpackage

// File: rtl/fetch_id_stage_imm_sel_decode.sv
// imm_sel_decode: combinational opcode -> ImmSel mapping.
// Ports:
//   opcode_i   [6:0]  instruction opcode field
//   imm_sel_o  [1:0]  immediate format (IMM_I/S/B/J)
// U-type opcodes fall into the default (I) since the extender routes Imm_U
// independently of ImmSel.
module imm_sel_decode
    import fetch_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [1:0] imm_sel_o
);

    always_comb begin
        imm_sel_o = IMM_I;
        case (opcode_i)
            OP_IMM, OP_LOAD, OP_JALR: imm_sel_o = IMM_I;
            OP_STORE:                 imm_sel_o = IMM_S;
            OP_BRANCH:                imm_sel_o = IMM_B;
            OP_JAL:                   imm_sel_o = IMM_J;
            default:                  imm_sel_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/fetch_id_stage.sv
// fetch_id_stage: instruction fetch plus IF/ID pipeline register.
// Keeps one instruction-memory request outstanding, captures the returned
// word into ID (or a one-entry skid buffer while ID is stalled), and handles
// redirects including discarding a response that is already in flight.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/imem_addr       fetch request (held until imem_valid) and PC
//   imem_rdata/imem_valid    returned word and its 1-cycle strobe
//   stall                    ID cannot accept; ID registers hold
//   redirect_valid/_pc       flush and refetch from redirect_pc (word aligned)
//   id_valid/id_pc/id_inst   ID stage contents
//   inst                     id_inst[31:7] for the immediate extender
//   ImmSel                   registered immediate format for id_inst
// Optional (macro FETCH_PERF_EN):
//   fetch_count, bubble_count  real-instruction and bubble load counters
module fetch_id_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [24:0] inst,
    output logic [1:0]  ImmSel
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [1:0]  sel_q, sel_d;
    // Skid buffer occupancy is encoded by state HOLD; only the payload is stored.
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        ld_real, ld_bubble;
    logic [31:0] ld_word, ld_pc;
    logic [1:0]  ld_sel;

    imm_sel_decode u_dec (
        .opcode_i  (ld_word[6:0]),
        .imm_sel_o (ld_sel)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        sel_d       = sel_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        ld_real     = 1'b0;
        ld_bubble   = 1'b0;
        ld_word     = imem_rdata;
        ld_pc       = pc_q;

        if (redirect_valid) begin
            // Flush wins over stall. A request still in flight must be
            // swallowed in DROP so its data never reaches ID.
            pc_d      = {redirect_pc[31:2], 2'b00};
            ld_bubble = 1'b1;
            case (state_q)
                FETCH, DROP: state_d = imem_valid ? FETCH : DROP;
                default:     state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = FETCH;
                    ld_bubble = !stall;
                end
                FETCH: begin
                    if (imem_valid) begin
                        pc_d = pc_q + 32'd4;
                        if (stall) begin
                            skid_pc_d   = pc_q;
                            skid_inst_d = imem_rdata;
                            state_d     = HOLD;
                        end else begin
                            ld_real = 1'b1;
                        end
                    end else begin
                        ld_bubble = !stall;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ld_real = 1'b1;
                        ld_word = skid_inst_q;
                        ld_pc   = skid_pc_q;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (imem_valid) state_d = FETCH;
                    ld_bubble = !stall;
                end
                default: state_d = IDLE;
            endcase
        end

        if (ld_real) begin
            id_valid_d = 1'b1;
            id_pc_d    = ld_pc;
            id_inst_d  = ld_word;
            sel_d      = ld_sel;
        end else if (ld_bubble) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            sel_d      = IMM_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= NOP_INST;
            sel_q       <= IMM_I;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            sel_q       <= sel_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign inst      = id_inst_q[31:7];
    assign ImmSel    = sel_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (ld_real)             fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (ld_bubble && !stall) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_id_stage.md
Name: fetch_id_stage

Overview:
- Instruction fetch plus IF/ID pipeline register for the RISC-V core.
- Drives the PC and a single-outstanding instruction-memory request, and captures the returned word.
- Presents the word to the immediate extender as inst[31:7], together with a registered ImmSel decoded from the opcode.
- Handles stall (hold), redirect (flush and new PC) and discarding of stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, word placed in ID on reset, flush or bubble (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  32  fetch address (current PC)
imem_rdata  in  32  returned instruction word
imem_valid  in  1  response strobe, 1 cycle, ≥1 cycle after request
stall  in  1  ID stage cannot accept; hold ID registers
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new PC; bits [1:0] cleared on load
id_valid  out  1  ID registers hold a real instruction
id_pc  out  32  PC of the ID instruction
id_inst  out  32  full instruction word in ID
inst  out  25  id_inst[31:7], feeds extender inst port
ImmSel  out  2  immediate format for extender

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - id_valid=0, id_pc=0, id_inst=NOP_INST, ImmSel=00.
  - Skid buffer empty.
- States:
  - IDLE → FETCH on the first clock after rst deasserts.
  - FETCH: imem_req=1, imem_addr=pc. Exactly one request outstanding.
  - HOLD: response buffered while stalled; imem_req=0.
  - DROP: a stale response is pending; imem_req=0.
- FETCH, imem_valid=1, stall=0:
  - At the next edge, ID loads {1, pc, rdata}; pc <= pc+4 (wraps mod 2^32); stay in FETCH.
  - Latency: response cycle t → id_valid/id_inst/ImmSel visible at t+1.
- FETCH, imem_valid=1, stall=1:
  - rdata and pc go to the skid buffer; pc <= pc+4; go to HOLD. ID registers unchanged.
- HOLD, stall=0: buffer moves to ID, buffer clears, go to FETCH.
- No new word and stall=0: ID takes a bubble (id_valid=0, id_inst=NOP_INST, ImmSel=00).
- stall=1: every ID register and ImmSel hold their value.
- redirect_valid=1 has top priority, in any state and regardless of stall:
  - pc <= {redirect_pc[31:2],2'b00}.
  - ID is flushed to the bubble; the skid buffer clears.
  - FETCH with no imem_valid this cycle → DROP. DROP waits for imem_valid, discards it, then → FETCH.
  - FETCH with imem_valid this same cycle → the response is discarded; → FETCH.
  - HOLD, DROP or IDLE → FETCH (DROP stays in DROP if its response is still pending).
- ImmSel is registered with id_inst, decoded from opcode [6:0]:
  - 0010011, 0000011, 1100111 → 00 (I)
  - 0100011 → 01 (S)
  - 1100011 → 10 (B)
  - 1101111 → 11 (J)
  - any other opcode → 00
  - U-type uses the extender's Imm_U output regardless of ImmSel.
- inst is always equal to id_inst[31:7].
- An imem_valid arriving in IDLE or HOLD is a protocol error and is ignored.

Optional Feature:
- Macro name: FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count[31:0] and output bubble_count[31:0].
  - fetch_count increments when ID loads a real instruction.
  - bubble_count increments each cycle ID loads a bubble while stall=0 (flushes included).
  - Both reset to 0 and wrap.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package/include fetch_pkg:
  - Opcode constants OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL.
  - ImmSel encodings IMM_I/S/B/J.
  - NOP_INST default.
  - State encodings IDLE/FETCH/HOLD/DROP.
- Sub-module imm_sel_decode: combinational opcode → ImmSel, reused by the control unit.

Test Plan:
1. Reset then 1-cycle memory returning 0xFE1FA4E3 (BRANCH) at 0x0 → imem_addr 0x0; next cycle id_valid=1, id_pc=0x0, inst=25'h1FC3F49, ImmSel=10.
2. Stream SW (0x00A12223), JAL (0x008000EF), LUI (0x000012B7) → ImmSel 01, 11, 00 in order; id_pc 0x0, 0x4, 0x8.
3. Hold stall=1 across a response at pc 0x10 → ID unchanged and imem_req=0; release → id_pc=0x10 next cycle, then fetch from 0x14.
4. Redirect to 0x103 while a 3-cycle response is pending → pending word discarded; next imem_addr=0x100; id_valid=0 until 0x100 returns.
5. Redirect coincident with imem_valid and stall=1 → word discarded, ID flushed to NOP_INST, fetch restarts at the redirect PC.
6. Assert rst mid-HOLD; pc=0xFFFFFFFC then wrap → all outputs at reset values immediately; the pc+4 case yields imem_addr 0x0.
